// File: rtl/add_arbiter.sv
// Round-robin arbiter that time-shares one external registered adder among four
// requesters, with exactly one operand pair in flight at a time.
module add_arbiter #(
  parameter int WIDTH     = 8,
  parameter int RES_WIDTH = 9,
  parameter int NUM_REQ   = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_b,
  output logic [WIDTH-1:0]           o_add_a,
  output logic [WIDTH-1:0]           o_add_b,
  input  logic [RES_WIDTH-1:0]       i_add_sum,
  output logic                       o_res_valid,
  input  logic                       i_res_ready,
  output logic [1:0]                 o_res_id,
  output logic [RES_WIDTH-1:0]       o_res_sum,
  output logic                       o_busy
);

  localparam int ID_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ID_W-1:0]       r_ptr;
  logic [WIDTH-1:0]      r_op_a;
  logic [WIDTH-1:0]      r_op_b;
  logic [ID_W-1:0]       r_res_id;
  logic [RES_WIDTH-1:0]  r_res_sum;
  logic                  r_res_valid;

  logic                  w_grant_any;
  logic [ID_W-1:0]       w_grant_idx;
  logic                  w_accept;

  // Scan from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      logic [ID_W-1:0] cand;
      cand = r_ptr + ID_W'(k);
      if (i_req_valid[cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = cand;
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_grant_any;

  // The accept strobe is combinational, so it is masked by reset directly.
  always_comb begin
    o_req_ready = '0;
    if (w_accept && i_rst_n) o_req_ready[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_res_id    <= '0;
      r_res_sum   <= '0;
      r_res_valid <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_a   <= i_req_a[w_grant_idx*WIDTH +: WIDTH];
            r_op_b   <= i_req_b[w_grant_idx*WIDTH +: WIDTH];
            r_res_id <= w_grant_idx;
            r_ptr    <= w_grant_idx + ID_W'(1);
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          r_res_sum   <= i_add_sum;
          r_res_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_add_a     = r_op_a;
  assign o_add_b     = r_op_b;
  assign o_res_valid = r_res_valid;
  assign o_res_id    = r_res_id;
  assign o_res_sum   = r_res_sum;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: a transaction-level model of the grant
// order and result latency, plus directed and randomized requester traffic.
module tb_add_arbiter;

  localparam int W  = 8;
  localparam int RW = 9;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]  add_a, add_b;
  logic [RW-1:0] add_sum;
  logic          res_valid, res_ready;
  logic [1:0]    res_id;
  logic [RW-1:0] res_sum;
  logic          busy;

  add_arbiter #(.WIDTH(W), .RES_WIDTH(RW), .NUM_REQ(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b),
    .o_add_a(add_a), .o_add_b(add_b), .i_add_sum(add_sum),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_id(res_id), .o_res_sum(res_sum), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // External adder: result one cycle after the operands are presented.
  always @(posedge clk) add_sum <= RW'(add_a) + RW'(add_b);

  // Requester sources
  bit pend[N];
  int src_a[N], src_b[N];
  bit hold_all;

  // Reference model: age = cycles since accept (1..3, 3 = result held), -1 = idle
  int m_age, m_ptr, m_id, m_sum, m_a, m_b;
  int n_done, last_id, last_sum, last_cyc, cyc;
  int n_cmp, n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = pend[i];
      req_a[i*W +: W]   = W'(src_a[i]);
      req_b[i*W +: W]   = W'(src_b[i]);
    end
  endfunction

  function automatic void new_req(input int i);
    pend[i]  = 1'b1;
    src_a[i] = int'($urandom_range(0, 255));
    src_b[i] = int'($urandom_range(0, 255));
  endfunction

  // One clock cycle: called at a falling edge with sources set for this cycle.
  task automatic cycle();
    int g;
    bit acc;
    logic [N-1:0] exp_rdy;
    drive();
    #1;
    g = 0; acc = 1'b0; exp_rdy = '0;
    if (m_age < 0)
      for (int k = N - 1; k >= 0; k--)
        if (pend[(m_ptr + k) % N]) begin
          g = (m_ptr + k) % N;
          acc = 1'b1;
        end
    if (acc) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("busy", 32'(busy), 32'(m_age >= 0));
    check("res_valid", 32'(res_valid), 32'(m_age == 3));
    if (m_age == 3) begin
      check("res_id", 32'(res_id), m_id);
      check("res_sum", 32'(res_sum), m_sum);
    end
    if (m_age == 1) begin
      check("add_a", 32'(add_a), m_a);
      check("add_b", 32'(add_b), m_b);
    end
    if (acc) begin
      m_age = 1; m_ptr = (g + 1) % N; m_id = g;
      m_a = src_a[g]; m_b = src_b[g]; m_sum = m_a + m_b;
      pend[g] = 1'b0;
    end else if (m_age == 1 || m_age == 2) begin
      m_age++;
    end else if (m_age == 3 && res_ready) begin
      m_age = -1;
      n_done++;
      last_id = int'(res_id); last_sum = int'(res_sum); last_cyc = cyc;
    end
    if (hold_all)
      for (int i = 0; i < N; i++) if (!pend[i]) new_req(i);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until(input int target, input int budget);
    while (n_done < target && budget > 0) begin
      cycle();
      budget--;
    end
    if (n_done < target) check("result_timeout", 32'(n_done), 32'(target));
  endtask

  task automatic drain(input int budget);
    bit any;
    any = 1'b1;
    while (any && budget > 0) begin
      cycle();
      budget--;
      any = (m_age >= 0);
      for (int i = 0; i < N; i++) any |= pend[i];
    end
    if (any) check("drain_timeout", 32'(any), 32'd0);
  endtask

  task automatic wait_age(input int age, input int budget);
    while (m_age != age && budget > 0) begin
      cycle();
      budget--;
    end
    if (m_age != age) check("age_timeout", 32'(m_age), 32'(age));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_id"},    32'(res_id),    32'd0);
    check({tag, "_sum"},   32'(res_sum),   32'd0);
    check({tag, "_add_a"}, 32'(add_a),     32'd0);
    check({tag, "_add_b"}, 32'(add_b),     32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  int fair_id[$], fair_cyc[$];
  int exp_fair[5];
  int sv;

  initial begin
    n_cmp = 0; n_err = 0; n_done = 0; cyc = 0; hold_all = 1'b0;
    m_age = -1; m_ptr = 0; m_id = 0; m_sum = 0; m_a = 0; m_b = 0;
    res_ready = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b1; src_a[i] = 0; src_b[i] = 0; end

    // Reset state, with every requester valid to show req_ready is masked
    rst_n = 1'b0;
    drive();
    #2;
    check_all_zero("reset");
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single request on requester 0
    res_ready = 1'b1;
    pend[0] = 1'b1; src_a[0] = 200; src_b[0] = 100;
    run_until(n_done + 1, 20);
    check("single_sum", 32'(last_sum), 32'd300);
    check("single_id", 32'(last_id), 32'd0);

    // Maximum operands on requester 3
    pend[3] = 1'b1; src_a[3] = 255; src_b[3] = 255;
    run_until(n_done + 1, 20);
    check("max_sum", 32'(last_sum), 32'd510);
    check("max_id", 32'(last_id), 32'd3);

    // Fairness with all requesters continuously valid
    hold_all = 1'b1;
    for (int i = 0; i < N; i++) new_req(i);
    for (int r = 0; r < 5; r++) begin
      run_until(n_done + 1, 20);
      fair_id.push_back(last_id);
      fair_cyc.push_back(last_cyc);
    end
    hold_all = 1'b0;
    exp_fair = '{0, 1, 2, 3, 0};
    for (int r = 0; r < 5; r++) check("fair_order", 32'(fair_id[r]), 32'(exp_fair[r]));
    for (int r = 1; r < 5; r++) check("fair_period", 32'(fair_cyc[r] - fair_cyc[r-1]), 32'd4);
    drain(100);

    // Backpressure in DONE while another requester waits
    res_ready = 1'b0;
    new_req(1);
    wait_age(3, 20);
    new_req(2);
    sv = m_sum;
    for (int c = 0; c < 5; c++) cycle();
    check("bp_sum_held", 32'(res_sum), 32'(sv));
    check("bp_busy", 32'(busy), 32'd1);
    res_ready = 1'b1;
    cycle();
    drive();
    #1;
    check("bp_next_grant", 32'(req_ready), 32'b0100);
    @(negedge clk); cyc++;
    // the cycle above was consumed outside the model; replay it as the grant
    m_age = 1; m_ptr = 3; m_id = 2; m_a = src_a[2]; m_b = src_b[2];
    m_sum = m_a + m_b; pend[2] = 1'b0;
    drain(50);

    // Asynchronous reset during WAIT discards the in-flight operation
    new_req(2);
    wait_age(2, 20);
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    m_age = -1; m_ptr = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    new_req(2);
    new_req(3);
    run_until(n_done + 1, 20);
    check("postreset_id", 32'(last_id), 32'd2);
    drain(50);

    // Operand sweep
    for (int a = 255; a >= 0; a -= 11)
      for (int b = 255; b >= 0; b--) begin
        int i;
        i = (a + b) % N;
        pend[i] = 1'b1; src_a[i] = a; src_b[i] = b;
        run_until(n_done + 1, 10);
        check("sweep_sum", 32'(last_sum), 32'(a + b));
      end

    // Randomized traffic with random consumer backpressure
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) new_req(i);
      res_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    res_ready = 1'b1;
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand width in bits.
REQ-002 The block SHALL have parameter RES_WIDTH, default 9, the result width; legal values are RES_WIDTH >= WIDTH+1.
REQ-003 The block SHALL have parameter NUM_REQ, default 4, the requester count; the fixed value is 4 and ID width is 2.
REQ-004 Clock  input  1  single clock; all state updates on the rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester operand-pair valid.
REQ-007 req_ready  output  NUM_REQ  per-requester accept strobe, one-hot or zero.
REQ-008 req_a  input  NUM_REQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 req_b  input  NUM_REQ*WIDTH  operand b; packed the same way as req_a.
REQ-010 add_a  output  WIDTH  operand a to the shared external adder.
REQ-011 add_b  output  WIDTH  operand b to the shared external adder.
REQ-012 add_sum  input  RES_WIDTH  adder result; valid exactly 1 cycle after add_a/add_b are presented.
REQ-013 res_valid  output  1  result available.
REQ-014 res_ready  input  1  consumer accepts result.
REQ-015 res_id  output  2  index of the requester that owns the result.
REQ-016 res_sum  output  RES_WIDTH  registered result.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-019 IDLE: if any req_valid bit is set, the block SHALL grant exactly one requester g by round-robin, searching from ptr, ptr+1, ... mod 4.
REQ-020 In IDLE, req_ready[g] SHALL be driven combinationally high for that cycle only; all other req_ready bits SHALL be 0, and every req_ready bit SHALL be 0 in all other states.
REQ-021 On the accept edge, the block SHALL capture req_a[g] and req_b[g] into operand registers, capture g into res_id, set ptr to (g+1) mod 4, and go to ISSUE.
REQ-022 add_a and add_b SHALL always reflect the operand registers.
REQ-023 ISSUE SHALL last 1 cycle, during which the operands are presented to the adder, then go to WAIT.
REQ-024 WAIT SHALL capture add_sum into res_sum on its closing edge, then go to DONE.
REQ-025 DONE SHALL hold res_valid=1 with res_sum and res_id stable until a cycle in which res_ready=1.
REQ-026 On that res_ready edge, the block SHALL clear res_valid and go to IDLE.
REQ-027 Latency: accept at cycle T SHALL give res_valid high from cycle T+3; with res_ready tied high, throughput SHALL be 1 result per 4 cycles.
REQ-028 Exactly one transaction SHALL be in flight; req_valid changes outside IDLE SHALL have no effect.
REQ-029 Requesters SHALL hold req_valid and operands stable until accepted; the block SHALL NOT require any req_valid deassertion between transactions.
REQ-030 Arithmetic: res_sum SHALL equal the zero-extended a plus b, with no truncation for all WIDTH-bit inputs (255+255 = 510 fits in 9 bits).
REQ-031 ptr SHALL advance only on accept; an idle cycle SHALL leave ptr unchanged.
REQ-032 When all 4 requesters are continuously valid, the grant order SHALL be 0,1,2,3,0,...
REQ-033 res_ready asserted while res_valid=0 SHALL be ignored.

Reset
REQ-034 Reset_n low SHALL immediately, without waiting for Clock, force state=IDLE, ptr=0, req_ready=0, res_valid=0, res_sum=0, res_id=0, add_a=0, add_b=0 and busy=0.
REQ-035 Reset mid-transaction SHALL discard the in-flight operation, and no res_valid SHALL follow it.
REQ-036 After Reset_n rises, the first grant SHALL search from requester 0.

Verification
REQ-037 Single request: req_valid=0001, a0=200, b0=100, res_ready=1 -> req_ready=0001 for 1 cycle; res_valid 3 cycles later with res_sum=300, res_id=0.
REQ-038 Max operands: a=255, b=255 on requester 3 -> res_sum=510, res_id=3, with no wrap.
REQ-039 Fairness: req_valid=1111 held, res_ready=1 -> res_id sequence 0,1,2,3,0, with one result per 4 cycles.
REQ-040 Backpressure: res_ready=0 for 5 cycles in DONE -> res_valid, res_sum and res_id stay stable and req_ready stays 0; res_ready=1 -> IDLE, next grant 1 cycle later.
REQ-041 Reset in WAIT: assert Reset_n=0 asynchronously mid-cycle -> all outputs 0 immediately; after release with req_valid=0100 -> the grant goes to requester 2 and no stale result appears.
REQ-042 Sweep: a stepping 255 down to 0 by 11 against b stepping 255 down to 0, on requester i = (a+b) mod 4 -> every res_sum equals a+b.
